core_mem_arbiter: RTL and testbench

//   Shares one memory port between the RV32I core's instruction fetch and data load/store paths.

---
 rtl/core_mem_pkg.sv | 18 +
 rtl/core_mem_arbiter_if.sv | 37 +++
 rtl/core_ifetch_buf.sv | 42 ++++
 rtl/core_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_core_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared types and defaults for the core memory-port arbiter
package core_mem_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;

    typedef enum logic {OWN_IF, OWN_D} owner_e;

    typedef struct packed {
        logic                  we;
        logic [AW_DEF-1:0]     addr;
        logic [XLEN_DEF-1:0]   wdata;
        logic [XLEN_DEF/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - core-side and memory-side handshake bundle for core_mem_arbiter
interface core_mem_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;
    logic              core_stall;
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [XLEN/8-1:0] m_be;
    logic              m_rvalid;
    logic [XLEN-1:0]   m_rdata;

    // master is the arbiter; slave is the core plus memory surrounding it
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
        output if_rvalid, if_rdata, d_rvalid, d_rdata, core_stall, m_valid, m_we, m_addr, m_wdata, m_be
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
        input  if_rvalid, if_rdata, d_rvalid, d_rdata, core_stall, m_valid, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/core_ifetch_buf.sv
// rtl/core_ifetch_buf.sv - single-entry fetch buffer: tag/data/valid with hit and store invalidation
module core_ifetch_buf
    import core_mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   lookup_addr,
    output logic            hit,
    output logic [XLEN-1:0] hit_data,
    input  logic            fill,
    input  logic [AW-1:0]   fill_addr,
    input  logic [XLEN-1:0] fill_data,
    input  logic            inv,
    input  logic [AW-1:0]   inv_addr
);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    logic            valid;
    logic [AW-1:0]   tag;
    logic [XLEN-1:0] data;

    assign hit      = valid && (lookup_addr == tag);
    assign hit_data = data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (inv && ((inv_addr & WORD_MASK) == (tag & WORD_MASK))) begin
            // a store anywhere in the buffered word makes the copy stale
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one memory port between fetch and data; IF_CACHE_EN adds a one-entry fetch buffer
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int AW         = AW_DEF,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    core_mem_arbiter_if.master bus
);
    arb_state_e        state, state_nxt;
    owner_e            owner;
    logic              m_we_r;
    logic [AW-1:0]     m_addr_r;
    logic [XLEN-1:0]   m_wdata_r;
    logic [XLEN/8-1:0] m_be_r;
    logic              if_rvalid_r, d_rvalid_r;
    logic [XLEN-1:0]   if_rdata_r, d_rdata_r;
    logic              if_pend, d_pend, grant_d, grant_if;
    logic              latch, complete, cache_serve;
    logic              hit;
    logic [XLEN-1:0]   hit_data;

    // a client whose response pulses this cycle is dropping or changing its request
    assign if_pend  = bus.if_req & ~if_rvalid_r;
    assign d_pend   = bus.d_req & ~d_rvalid_r;
    assign grant_d  = d_pend & (DATA_FIRST | ~if_pend);
    assign grant_if = if_pend & ~grant_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch       = 1'b0;
        complete    = 1'b0;
        cache_serve = 1'b0;
        case (state)
            IDLE: begin
                if (grant_if && hit) begin
                    cache_serve = 1'b1;
                end else if (grant_d || grant_if) begin
                    latch     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.m_ready) begin
                    complete  = bus.m_rvalid;
                    state_nxt = bus.m_rvalid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus.m_rvalid) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= OWN_IF;
            m_we_r      <= 1'b0;
            m_addr_r    <= '0;
            m_wdata_r   <= '0;
            m_be_r      <= '0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
        end else begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if (latch) begin
                owner     <= grant_d ? OWN_D : OWN_IF;
                m_we_r    <= grant_d & bus.d_we;
                m_addr_r  <= grant_d ? bus.d_addr : bus.if_addr;
                m_wdata_r <= grant_d ? bus.d_wdata : '0;
                m_be_r    <= grant_d ? bus.d_be : '1;
            end
            if (cache_serve) begin
                if_rvalid_r <= 1'b1;
                if_rdata_r  <= hit_data;
            end
            if (complete) begin
                if (owner == OWN_D) begin
                    d_rvalid_r <= 1'b1;
                    if (!m_we_r) d_rdata_r <= bus.m_rdata;
                end else begin
                    if_rvalid_r <= 1'b1;
                    if_rdata_r  <= bus.m_rdata;
                end
            end
        end
    end

`ifdef IF_CACHE_EN
    core_ifetch_buf #(.XLEN(XLEN), .AW(AW)) u_ifetch_buf (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (bus.if_addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .fill        (complete && (owner == OWN_IF)),
        .fill_addr   (m_addr_r),
        .fill_data   (bus.m_rdata),
        .inv         (latch && grant_d && bus.d_we),
        .inv_addr    (bus.d_addr)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign bus.m_valid    = (state == REQ);
    assign bus.m_we       = m_we_r;
    assign bus.m_addr     = m_addr_r;
    assign bus.m_wdata    = m_wdata_r;
    assign bus.m_be       = m_be_r;
    assign bus.if_rvalid  = if_rvalid_r;
    assign bus.if_rdata   = if_rdata_r;
    assign bus.d_rvalid   = d_rvalid_r;
    assign bus.d_rdata    = d_rdata_r;
    assign bus.core_stall = if_pend | d_pend;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed and randomized checks of core_mem_arbiter against a word-array memory model
module tb_core_mem_arbiter;
    import core_mem_pkg::*;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_mem_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    core_mem_arbiter #(.XLEN(XLEN), .AW(AW), .DATA_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_if_pulse = 0, n_d_pulse = 0, n_if_done = 0, n_d_done = 0;
    logic [31:0] exp_d_rdata = '0;

    // reference memory (what the core should observe) and the bus-side memory
    logic [31:0] ref_mem [256];
    logic [31:0] bus_mem [256];
    logic        load_mem  = 1'b0;
    int          stall_cfg = 0;
    int          lat_cfg   = 0;
    int          vcnt = 0, lcnt = 0;
    logic        busy = 1'b0, rv_pulse = 1'b0;
    logic [31:0] rd_hold = '0;
    logic        accept;
    mem_req_t    bus_log[$];

    assign accept       = bus.m_valid && bus.m_ready;
    assign bus.m_ready  = bus.m_valid && !busy && (vcnt >= stall_cfg);
    assign bus.m_rvalid = (lat_cfg == 0) ? accept : rv_pulse;
    assign bus.m_rdata  = (lat_cfg == 0) ? bus_mem[bus.m_addr[9:2]] : rd_hold;

    always @(posedge clk) begin
        rv_pulse <= 1'b0;
        if (load_mem) for (int i = 0; i < 256; i++) bus_mem[i] <= ref_mem[i];
        if (bus.m_valid && !accept) vcnt <= vcnt + 1;
        else                        vcnt <= 0;
        if (accept) begin
            bus_log.push_back(mem_req_t'{we: bus.m_we, addr: bus.m_addr, wdata: bus.m_wdata, be: bus.m_be});
            if (bus.m_we)
                for (int b = 0; b < 4; b++)
                    if (bus.m_be[b]) bus_mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            if (lat_cfg > 0) begin
                busy    <= 1'b1;
                lcnt    <= lat_cfg;
                rd_hold <= bus_mem[bus.m_addr[9:2]];
            end
        end else if (busy) begin
            if (lcnt == 1) begin
                rv_pulse <= 1'b1;
                busy     <= 1'b0;
            end
            lcnt <= lcnt - 1;
        end
    end

    always @(negedge clk) begin
        if (bus.if_rvalid) n_if_pulse <= n_if_pulse + 1;
        if (bus.d_rvalid)  n_d_pulse  <= n_d_pulse + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_m_valid"},   32'(bus.m_valid),   32'd0);
        chk({pfx, "_m_we"},      32'(bus.m_we),      32'd0);
        chk({pfx, "_m_addr"},    bus.m_addr,         32'd0);
        chk({pfx, "_m_wdata"},   bus.m_wdata,        32'd0);
        chk({pfx, "_m_be"},      32'(bus.m_be),      32'd0);
        chk({pfx, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({pfx, "_d_rvalid"},  32'(bus.d_rvalid),  32'd0);
        chk({pfx, "_if_rdata"},  bus.if_rdata,       32'd0);
        chk({pfx, "_d_rdata"},   bus.d_rdata,        32'd0);
    endtask

    // cycles are counted in negedges from the drive point to the rvalid sample
    task automatic do_fetch(input logic [31:0] a, output int lat, output int stalls);
        logic [31:0] expd;
        expd = ref_mem[a[9:2]];
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        lat    = 0;
        stalls = 0;
        #1 if (bus.core_stall) stalls++;
        do begin
            @(negedge clk);
            lat++;
            if (bus.core_stall) stalls++;
        end while (!bus.if_rvalid && lat < 60);
        chk("fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("fetch_data", bus.if_rdata, expd);
        n_if_done++;
        bus.if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output int lat);
        logic [31:0] expd;
        expd = ref_mem[a[9:2]];
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_be    = be;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.d_rvalid && lat < 60);
        chk("data_rvalid", 32'(bus.d_rvalid), 32'd1);
        if (we) begin
            chk("store_keeps_d_rdata", bus.d_rdata, exp_d_rdata);
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            chk("load_data", bus.d_rdata, expd);
            exp_d_rdata = expd;
        end
        n_d_done++;
        bus.d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat2, st, n0, mv, pre;
        logic [31:0] a0, a1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h0051_0113;

        @(negedge clk);
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
        chk_reset_outputs("reset");
        chk("reset_core_stall", 32'(bus.core_stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single fetch against zero-wait memory
        do_fetch(32'h10, lat, st);
        chk("t1_latency", lat, 2);
        chk("t1_stall_cycles", st, 2);
        chk("t1_rdata", bus.if_rdata, 32'h0051_0113);
        do_fetch(32'h0C, lat, st);

        // simultaneous fetch and load: data wins, fetch follows immediately
        bus_log.delete();
        fork
            do_fetch(32'h10, lat2, st);
            do_data(1'b0, 32'h100, 32'h0, 4'hF, lat);
        join
        a0 = (bus_log.size() > 0) ? bus_log[0].addr : 32'hFFFF_FFFF;
        a1 = (bus_log.size() > 1) ? bus_log[1].addr : 32'hFFFF_FFFF;
        chk("t2_bus_count", bus_log.size(), 2);
        chk("t2_first_addr", a0, 32'h100);
        chk("t2_second_addr", a1, 32'h10);
        chk("t2_d_latency", lat, 2);
        chk("t2_if_latency", lat2, 4);

        // store held under memory backpressure
        stall_cfg = 4;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
        lat = 0; mv = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.m_valid) begin
                mv++;
                chk("t3_payload_stable", 32'(bus.m_we && bus.m_addr == 32'h200 &&
                    bus.m_wdata == 32'hDEAD_BEEF && bus.m_be == 4'b0011), 32'd1);
            end
        end while (!bus.d_rvalid && lat < 60);
        chk("t3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("t3_m_valid_cycles", mv, 5);
        chk("t3_latency", lat, 6);
        chk("t3_d_rdata_kept", bus.d_rdata, exp_d_rdata);
        ref_mem[128][15:0] = 16'hBEEF;
        chk("t3_mem_written", bus_mem[128], ref_mem[128]);
        n_d_done++;
        bus.d_req = 1'b0;
        stall_cfg = 0;

        // repeated fetch, then a store into the same word, then refetch
        n0 = bus_log.size();
        do_fetch(32'h20, lat, st);
        chk("t5_first_latency", lat, 2);
        @(negedge clk);
        do_fetch(32'h20, lat, st);
`ifdef IF_CACHE_EN
        chk("t5_hit_latency", lat, 1);
        chk("t5_hit_no_bus", bus_log.size(), n0 + 1);
`else
        chk("t5_refetch_latency", lat, 2);
        chk("t5_refetch_bus", bus_log.size(), n0 + 2);
`endif
        do_data(1'b1, 32'h22, 32'h00AB_0000, 4'b0100, lat);
        @(negedge clk);
        n0 = bus_log.size();
        do_fetch(32'h20, lat, st);
        chk("t5_after_store_bus", bus_log.size(), n0 + 1);
        chk("t5_after_store_latency", lat, 2);

        // reset while the load waits for a slow response
        lat_cfg = 5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104; bus.d_be = 4'hF;
        @(negedge clk);
        chk("t4_req_m_valid", 32'(bus.m_valid), 32'd1);
        @(negedge clk);
        chk("t4_wait_m_valid", 32'(bus.m_valid), 32'd0);
        chk("t4_wait_stall", 32'(bus.core_stall), 32'd1);
        reset = 1'b0;
        bus.d_req = 1'b0;
        exp_d_rdata = '0;
        #1 chk_reset_outputs("t4_async");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        pre = n_d_pulse;
        repeat (8) @(negedge clk);
        #1 chk("t4_no_stale_pulse", n_d_pulse, pre);
        chk("t4_d_rdata_cleared", bus.d_rdata, 32'd0);
        @(negedge clk);
        do_data(1'b0, 32'h104, 32'h0, 4'hF, lat);

        // random interleaved traffic, 5-cycle memory latency
        stall_cfg = 1;
        fork
            begin
                logic [31:0] fa;
                int fl, fs;
                for (int i = 0; i < 50; i++) begin
                    fa = 32'($urandom_range(0, 63)) << 2;
                    do_fetch(fa, fl, fs);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                logic [31:0] da, dw;
                logic [3:0]  dbe;
                logic        dwe;
                int dl;
                for (int j = 0; j < 50; j++) begin
                    dwe = 1'($urandom_range(0, 1));
                    da  = dwe ? (32'($urandom_range(64, 255)) << 2) : (32'($urandom_range(0, 255)) << 2);
                    dw  = $urandom;
                    dbe = 4'($urandom_range(1, 15));
                    do_data(dwe, da, dw, dbe, dl);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (3) @(negedge clk);
        #1;
        chk("if_pulse_count", n_if_pulse, n_if_done);
        chk("d_pulse_count", n_d_pulse, n_d_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
